next_pc_seq: RTL

- Program-counter sequencer that sits directly downstream of SignExtender.
- Consumes the 64-bit sign-extended branch offset (Bout) and the decode control flags. It holds the fetch PC and a decode-stage PC register, resolves B, CBZ and CBNZ branches, and squashes the wrong-path instruction after a taken branch.
- Feeds the instruction memory address and the decode-stage valid and PC.

---
 rtl/next_pc_seq.sv | 121 ++++++++++++
 1 files changed

// File: rtl/next_pc_seq.sv
// next_pc_seq: program-counter sequencer downstream of the sign extender.
//   Holds the fetch PC and the decode-stage PC, resolves B/CBZ/CBNZ, and
//   squashes the single wrong-path instruction fetched behind a taken branch.
//
// Ports:
//   Clk          in   system clock, rising-edge
//   Resetn       in   synchronous active-low reset
//   Stall        in   hold PC, PCD and state
//   SignExtImm   in   word offset for the decode instruction
//   Uncondbranch in   decode instruction is B
//   Branch       in   decode instruction is CBZ/CBNZ
//   BranchNZ     in   1 = CBNZ, 0 = CBZ
//   Zero         in   ALU zero flag for the decode instruction
//   PC           out  fetch address
//   PCD          out  decode-stage instruction address
//   PCDPlus4     out  PCD + 4 (link value)
//   DecodeValid  out  decode slot holds a real instruction
//   Taken        out  combinational branch-taken
//   Target       out  combinational branch target
//   TakenCount   out  saturating taken-branch counter (BRANCH_STATS_EN only)
//
// Optional feature macro: BRANCH_STATS_EN
//
// state  | meaning
// BOOT   | first cycle after reset, decode slot empty
// RUN    | decode slot holds a real instruction
// SQUASH | decode slot holds the wrong-path instruction behind a taken branch
module next_pc_seq #(
  parameter int unsigned     PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            Clk,
  input  logic            Resetn,
  input  logic            Stall,
  input  logic [PC_W-1:0] SignExtImm,
  input  logic            Uncondbranch,
  input  logic            Branch,
  input  logic            BranchNZ,
  input  logic            Zero,
  output logic [PC_W-1:0] PC,
  output logic [PC_W-1:0] PCD,
  output logic [PC_W-1:0] PCDPlus4,
  output logic            DecodeValid,
  output logic            Taken,
  output logic [PC_W-1:0] Target
`ifdef BRANCH_STATS_EN
  ,
  output logic [15:0]     TakenCount
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    SQUASH = 2'd2
  } state_e;

  localparam logic [PC_W-1:0] PC_STEP = PC_W'(4);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] pcd_q, pcd_d;
  logic            run;

  assign run = (state_q == RUN);

  // Taken is gated by RUN so the squashed instruction and the boot slot can
  // never redirect fetch; this is what rules out back-to-back redirects.
  always_comb begin
    Target = pcd_q + (SignExtImm << 2);
    Taken  = run & (Uncondbranch | (Branch & (Zero ^ BranchNZ)));
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    pcd_d   = pcd_q;
    if (!Stall) begin
      pcd_d = pc_q;
      if (Taken) begin
        pc_d    = Target;
        state_d = SQUASH;
      end else begin
        pc_d    = pc_q + PC_STEP;
        state_d = RUN;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      pcd_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      pcd_q   <= pcd_d;
    end
  end

  assign PC          = pc_q;
  assign PCD         = pcd_q;
  assign PCDPlus4    = pcd_q + PC_STEP;
  assign DecodeValid = run;

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt_q;

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      taken_cnt_q <= '0;
    end else if (!Stall && Taken && (taken_cnt_q != 16'hFFFF)) begin
      taken_cnt_q <= taken_cnt_q + 16'd1;
    end
  end

  assign TakenCount = taken_cnt_q;
`endif

endmodule
